// File: rtl/multiport_register_file_if.sv
// Bus bundle for multiport_register_file: write port, clear request, flattened read ports, status.
// The master drives requests and addresses; the slave (register file) returns data and status.
interface multiport_register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                     clear_req;
  logic                     regWriteF;
  logic [ADDR_W-1:0]        writeReg;
  logic [DATA_W-1:0]        writeData;
  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic                     ready;
  logic                     clr_busy;

  modport master (
    output clear_req,
    output regWriteF,
    output writeReg,
    output writeData,
    output rdAddr,
    input  rdData,
    input  ready,
    input  clr_busy
  );

  modport slave (
    input  clear_req,
    input  regWriteF,
    input  writeReg,
    input  writeData,
    input  rdAddr,
    output rdData,
    output ready,
    output clr_busy
  );
endinterface

// File: rtl/multiport_register_file.sv
// Multi-read-port register file with hardwired-zero r0 and a hardware clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module multiport_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
) (
  input logic                      clock,
  input logic                      reset,
  multiport_register_file_if.slave bus
);

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StReady = 2'd1
  } state_e;

  // Terminal index and bound are held at full ADDR_W so NUM_REGS == 2**ADDR_W never wraps early.
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_valid;
  logic              is_ready;
  logic              fwd_en;

  function automatic logic idx_in_range(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NumRegsW);
  endfunction

  assign wr_valid     = bus.regWriteF && idx_in_range(bus.writeReg);
  assign is_ready     = (state_q == StReady);
  assign bus.ready    = is_ready;
  assign bus.clr_busy = ~is_ready;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_idx   = clr_idx_q;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        if (clr_idx_q == LastIdx) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      StReady: begin
        // A clear request outranks a coincident write; the write is dropped.
        if (bus.clear_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end else if (wr_valid) begin
          mem_we    = 1'b1;
          mem_idx   = bus.writeReg;
          mem_wdata = bus.writeData;
        end
      end
      default: begin
        state_d   = StClear;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage is RAM-style: no reset, contents defined once the clear sequence completes.
  always_ff @(posedge clock) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (mem_we && (mem_idx == ADDR_W'(r))) begin
        mem_q[r] <= mem_wdata;
      end
    end
  end

  always_comb begin
    fwd_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    fwd_en = is_ready && wr_valid && !bus.clear_req;
`endif
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = bus.rdAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data = '0;
      if (is_ready && idx_in_range(rd_addr)) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (rd_addr == ADDR_W'(r)) begin
            rd_data = mem_q[r];
          end
        end
        if (fwd_en && (rd_addr == bus.writeReg)) begin
          rd_data = bus.writeData;
        end
      end
    end

    assign bus.rdData[k*DATA_W +: DATA_W] = rd_data;
  end

`ifndef SYNTHESIS
  a_state_legal : assert property (@(posedge clock) disable iff (reset)
    (state_q == StClear) || (state_q == StReady));
  a_clr_idx_bound : assert property (@(posedge clock) disable iff (reset)
    {1'b0, clr_idx_q} < NumRegsW);
`endif

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: a 32-entry and a 16-entry file share one stimulus stream, checked against
// table vectors, hand sequences and an array-based reference model.
module tb_multiport_register_file;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int NR_A = 32;
  localparam int NR_B = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic              clear_req;
  logic              reg_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr [NUM_RD];

  multiport_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_a ();
  multiport_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_b ();

  assign bus_a.clear_req = clear_req;
  assign bus_a.regWriteF = reg_we;
  assign bus_a.writeReg  = waddr;
  assign bus_a.writeData = wdata;
  assign bus_a.rdAddr    = {raddr[1], raddr[0]};
  assign bus_b.clear_req = clear_req;
  assign bus_b.regWriteF = reg_we;
  assign bus_b.writeReg  = waddr;
  assign bus_b.writeData = wdata;
  assign bus_b.rdAddr    = {raddr[1], raddr[0]};

  multiport_register_file #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NR_A), .NUM_RD(NUM_RD)
  ) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  multiport_register_file #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NR_B), .NUM_RD(NUM_RD)
  ) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic [NUM_RD*DATA_W-1:0] rdd  [2];
  logic                     rdy  [2];
  logic                     busy [2];
  assign rdd[0]  = bus_a.rdData;
  assign rdd[1]  = bus_b.rdData;
  assign rdy[0]  = bus_a.ready;
  assign rdy[1]  = bus_b.ready;
  assign busy[0] = bus_a.clr_busy;
  assign busy[1] = bus_b.clr_busy;

  // Reference model: contents plus number of clear edges still owed (0 means ready).
  logic [DATA_W-1:0] mdl_mem  [2][32];
  int                mdl_left [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e0_fwd;
    logic [31:0] e1_fwd;
  } vec_t;
  vec_t vecs [12];

  function automatic int nr(input int d);
    return (d == 0) ? NR_A : NR_B;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int d, input logic [ADDR_W-1:0] a);
    if (mdl_left[d] != 0) return '0;
    if (a == 0 || int'(a) >= nr(d)) return '0;
    if (Fwd && reg_we && !clear_req && waddr != 0 && int'(waddr) < nr(d) && a == waddr)
      return wdata;
    return mdl_mem[d][a];
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) continue;
      if (mdl_left[d] > 0) begin
        mdl_left[d]--;
        if (mdl_left[d] == 0) begin
          for (int r = 0; r < 32; r++) mdl_mem[d][r] = '0;
        end
      end else if (clear_req) begin
        mdl_left[d] = nr(d);
      end else if (reg_we && waddr != 0 && int'(waddr) < nr(d)) begin
        mdl_mem[d][waddr] = wdata;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready[%0d]", d), {31'b0, rdy[d]}, {31'b0, mdl_left[d] == 0});
      check($sformatf("clr_busy[%0d]", d), {31'b0, busy[d]}, {31'b0, mdl_left[d] != 0});
      for (int k = 0; k < NUM_RD; k++) begin
        check($sformatf("rd%0d[%0d] a=%0d", k, d, raddr[k]), rdd[d][k*DATA_W +: DATA_W],
              model_read(d, raddr[k]));
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    check_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic set_idle();
    clear_req = 1'b0;
    reg_we    = 1'b0;
    waddr     = '0;
    wdata     = '0;
    raddr[0]  = '0;
    raddr[1]  = '0;
  endtask

  // Counts edges until each file reports ready; 0 means the bound expired.
  task automatic count_ready(input string tag);
    int ea = 0;
    int eb = 0;
    for (int n = 1; n <= 80; n++) begin
      cycle();
      if (ea == 0 && rdy[0]) ea = n;
      if (eb == 0 && rdy[1]) eb = n;
      if (ea != 0 && eb != 0) break;
    end
    check({tag, "_edges_a"}, ea, NR_A);
    check({tag, "_edges_b"}, eb, NR_B);
  endtask

  task automatic pulse_reset(input int hold);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready_falls_async[%0d]", d), {31'b0, rdy[d]}, 32'd0);
      mdl_left[d] = nr(d);
    end
    for (int i = 0; i < hold; i++) cycle();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9,
                 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd9,  32'h12345678, 5'd8,  5'd9,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h12345678};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd8,  5'd9,
                 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd8,  5'd8,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd8,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 5'd5,  32'hA5,       5'd5,  5'd9,
                 32'h0, 32'h12345678, 32'hA5, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                 32'hA5, 32'hA5, 32'hA5, 32'hA5};
    vecs[8]  = '{1'b0, 1'b1, 5'd5,  32'h5A,       5'd5,  5'd8,
                 32'hA5, 32'hDEADBEEF, 32'h5A, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31,
                 32'h5A, 32'h0, 32'h5A, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30,
                 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd1,
                 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};

    reset = 1'b1;
    set_idle();
    mdl_left[0] = NR_A;
    mdl_left[1] = NR_B;

    // Reset held for 3 cycles, then the initial clear.
    repeat (3) cycle();
    reset = 1'b0;
    count_ready("init");
    for (int a = 0; a < 32; a += 2) begin
      raddr[0] = a[4:0];
      raddr[1] = 5'(a + 1);
      cycle();
    end
    set_idle();

    // Directed vectors against the 32-entry file.
    foreach (vecs[i]) begin
      clear_req = vecs[i].clr;
      reg_we    = vecs[i].we;
      waddr     = vecs[i].wa;
      wdata     = vecs[i].wd;
      raddr[0]  = vecs[i].ra0;
      raddr[1]  = vecs[i].ra1;
      sample();
      check($sformatf("vec%0d_p0", i), rdd[0][31:0],  Fwd ? vecs[i].e0_fwd : vecs[i].e0);
      check($sformatf("vec%0d_p1", i), rdd[0][63:32], Fwd ? vecs[i].e1_fwd : vecs[i].e1);
      advance();
    end
    set_idle();

    // Out-of-range write on the 16-entry file is discarded.
    reg_we = 1'b1; waddr = 5'd4;  wdata = 32'h44; cycle();
    reg_we = 1'b1; waddr = 5'd20; wdata = 32'h5;  cycle();
    reg_we = 1'b0; raddr[0] = 5'd20; raddr[1] = 5'd4;
    sample();
    check("b_r20_discarded", rdd[1][31:0],  32'h0);
    check("b_r4_kept",       rdd[1][63:32], 32'h44);
    check("a_r20_written",   rdd[0][31:0],  32'h5);
    advance();
    set_idle();

    // Clear request wins over a coincident write.
    reg_we = 1'b1; waddr = 5'd7; wdata = 32'h777; cycle();
    clear_req = 1'b1; reg_we = 1'b1; waddr = 5'd7; wdata = 32'h1; raddr[0] = 5'd7;
    sample();
    check("clr_write_same_cycle_rd", rdd[0][31:0], 32'h777);
    advance();
    set_idle();
    count_ready("clear_req");
    raddr[0] = 5'd7;
    sample();
    check("r7_after_clear", rdd[0][31:0], 32'h0);
    advance();
    set_idle();

    // Reset at clear index 10 restarts the sequence.
    clear_req = 1'b1; cycle(); clear_req = 1'b0;
    repeat (10) cycle();
    pulse_reset(2);
    count_ready("reset_mid_clear");

    // Reset while ready drops ready without a clock edge.
    reg_we = 1'b1; waddr = 5'd3; wdata = 32'h33; cycle(); set_idle();
    pulse_reset(1);
    count_ready("reset_in_ready");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      clear_req = ($urandom_range(0, 59) == 0);
      reg_we    = ($urandom_range(0, 3) != 0);
      waddr     = 5'($urandom_range(0, 31));
      wdata     = $urandom;
      for (int k = 0; k < NUM_RD; k++) begin
        raddr[k] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
